// File: rtl/wb_pipe_memdev_if.sv
// Wishbone B4 pipelined bus between a master and the memory slave.
// The master drives the i_wb_* requests; the slave returns ack/err/stall/data and a sweep-busy flag.
interface wb_pipe_memdev_if #(
  parameter int DW = 32,
  parameter int AW = 11
);
  logic            i_wb_cyc;
  logic            i_wb_stb;
  logic            i_wb_we;
  logic [AW-1:0]   i_wb_addr;
  logic [DW-1:0]   i_wb_data;
  logic [DW/8-1:0] i_wb_sel;
  logic            o_wb_ack;
  logic            o_wb_err;
  logic            o_wb_stall;
  logic [DW-1:0]   o_wb_data;
  logic            o_busy;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    input  o_wb_ack, o_wb_err, o_wb_stall, o_wb_data, o_busy
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    output o_wb_ack, o_wb_err, o_wb_stall, o_wb_data, o_busy
  );
endinterface

// File: rtl/wb_pipe_memdev.sv
// Pipelined Wishbone memory slave: one request per cycle, ack/err LATENCY cycles after acceptance.
// Stalls only while the post-reset clear sweep runs; dropping cyc discards all in-flight responses.
module wb_pipe_memdev #(
  parameter int DW             = 32,
  parameter int DEPTH          = 1024,
  parameter int AW             = $clog2(DEPTH) + 1,
  parameter int LATENCY        = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic              clk,
  input logic              reset,
  wb_pipe_memdev_if.slave  bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int NB = DW / 8;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   sweep_q, sweep_d;
  logic            stall;
  logic            busy;

  logic [DW-1:0]   mem [DEPTH];
  logic            accept;
  logic            in_range;
  logic [IW-1:0]   widx;

  logic [LATENCY-1:0] ack_q, err_q;
  logic [DW-1:0]      dat_q [LATENCY];
  logic               ack_d, err_d;
  logic [DW-1:0]      dat_d;

  assign accept   = bus.i_wb_cyc & bus.i_wb_stb & ~stall;
  assign in_range = bus.i_wb_addr < AW'(DEPTH);
  assign widx     = bus.i_wb_addr[IW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == ST_INIT) begin
      sweep_d = sweep_q + IW'(1);
      if (sweep_q == IW'(DEPTH - 1)) begin
        state_d = ST_RUN;
        sweep_d = '0;
      end
    end
  end

  always_comb begin
    stall = 1'b0;
    busy  = 1'b0;
    if (state_q == ST_INIT) begin
      stall = 1'b1;
      busy  = 1'b1;
    end
  end

  // Memory contents survive reset; only the sweep clears them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == ST_INIT) begin
        mem[sweep_q] <= '0;
      end else if (accept && in_range && bus.i_wb_we) begin
        for (int b = 0; b < NB; b++) begin
          if (bus.i_wb_sel[b]) mem[widx][8*b +: 8] <= bus.i_wb_data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    ack_d = accept & in_range;
    err_d = accept & ~in_range;
    dat_d = (accept && in_range && !bus.i_wb_we) ? mem[widx] : '0;
  end

  // Response shift register; data is forced to zero whenever the slot holds no read ack.
  always_ff @(posedge clk) begin
    if (reset || !bus.i_wb_cyc) begin
      ack_q <= '0;
      err_q <= '0;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
    end else begin
      ack_q[0] <= ack_d;
      err_q[0] <= err_d;
      dat_q[0] <= dat_d;
      for (int i = 1; i < LATENCY; i++) begin
        ack_q[i] <= ack_q[i-1];
        err_q[i] <= err_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign bus.o_wb_ack   = ack_q[LATENCY-1];
  assign bus.o_wb_err   = err_q[LATENCY-1];
  assign bus.o_wb_data  = dat_q[LATENCY-1];
  assign bus.o_wb_stall = stall;
  assign bus.o_busy     = busy;
endmodule

// File: doc/wb_pipe_memdev.md
# wb_pipe_memdev

Parametrised Wishbone B4 pipelined-mode memory slave for the pipelined RISC-V core, the generalised successor of the fixed-size instruction/data memory device. It supports configurable data width, a depth that need not be a power of two, and a fixed read/write latency of 1–4 cycles with one request accepted per cycle. It adds byte-lane writes, out-of-range error responses, cycle-abort handling and an optional hardware clear-on-reset sweep. It sits behind the mem stage (and the fetch bus) in `top`.

## Interface
Parameters:
- `DW`, 32: data width in bits; multiple of 8.
- `DEPTH`, 1024: number of `DW`-bit words; any value ≥ 2.
- `AW`, `$clog2(DEPTH)`+1: word-address width. The extra bit allows out-of-range addresses to be expressed.
- `LATENCY`, 1: cycles from the acceptance edge to the response; legal range 1..4.
- `CLEAR_ON_RESET`, 1: when 1, zero every word after reset before accepting traffic.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `i_wb_cyc` in 1: bus cycle active.
- `i_wb_stb` in 1: request strobe.
- `i_wb_we` in 1: 1 = write, 0 = read.
- `i_wb_addr` in AW: word address.
- `i_wb_data` in DW: write data.
- `i_wb_sel` in DW/8: byte-lane enables; bit n covers bits [8n+7:8n].
- `o_wb_ack` out 1: successful response.
- `o_wb_err` out 1: error response (address ≥ DEPTH).
- `o_wb_stall` out 1: request not accepted this cycle.
- `o_wb_data` out DW: read data; valid only with `o_wb_ack`.
- `o_busy` out 1: clear sweep in progress.

## Operation
- Acceptance: a request is accepted on an edge where `i_wb_cyc & i_wb_stb & !o_wb_stall` holds. At most one request is accepted per cycle.
- State machine:
  - INIT is entered on reset when `CLEAR_ON_RESET`=1. In INIT, one word is zeroed per cycle at address 0,1,…,DEPTH-1, and `o_wb_stall`=`o_busy`=1. After writing word DEPTH-1 the block moves to RUN.
  - RUN is entered on reset when `CLEAR_ON_RESET`=0. In RUN, `o_wb_stall`=0 and `o_busy`=0.
- Reset does not itself alter memory contents; only the INIT sweep does.
- Write: the array is updated on the acceptance edge. Only lanes with `i_wb_sel`=1 change. `sel`=0 is a legal write that changes nothing and is still acked.
- Read: the word is sampled on the acceptance edge and delivered on `o_wb_data` with the ack.
- Ordering: responses are returned strictly in acceptance order. A read accepted on the edge after a write to the same address returns the new data.
- Range check: an access with `i_wb_addr` ≥ DEPTH is not written. It produces `o_wb_err` instead of `o_wb_ack`, with the same latency.
- Exactly one of ack/err is produced per accepted request, unless the request is aborted.
- Abort: any cycle with `i_wb_cyc`=0 discards every in-flight response; the dropped responses never appear. Writes already committed stay committed.
- `o_wb_data` is 0 in every cycle where `o_wb_ack`=0, including write acks and err responses.

## Timing
- Reset values:
  - `o_wb_ack`=0, `o_wb_err`=0, `o_wb_data`=0.
  - `o_wb_stall`=`o_busy`=`CLEAR_ON_RESET`.
  - Response pipeline cleared; sweep pointer = 0.
- INIT lasts exactly DEPTH cycles after `reset` deasserts; the first request can be accepted on the next edge.
- Latency: for a request accepted on edge k, `o_wb_ack`/`o_wb_err` is high during the cycle following edge k+LATENCY-1.
  - LATENCY=1: response in the cycle immediately after acceptance.
  - Back-to-back requests give back-to-back responses with no bubbles.
- Responses are single-cycle pulses, registered, with no combinational path from inputs.
- `o_wb_stall` is a registered or state-only function; it never depends on `i_wb_*`.
- Reset mid-operation: in-flight responses are dropped, the sweep pointer returns to 0, and INIT restarts if enabled.
- Reset during INIT restarts the sweep.
- `i_wb_stb` without `i_wb_cyc` is ignored.

## Test plan
- CLEAR_ON_RESET=1, DEPTH=10: release reset → `o_stall`/`o_busy` high for exactly 10 cycles. A read of address 7 then returns 0 with `ack` at latency.
- DW=32, LATENCY=1: write 0xDEADBEEF to addr 3 with sel=4'b1111, then write 0x00001200 with sel=4'b0010, then read addr 3 → data 0xDEAD12EF, one ack per request, three consecutive acks.
- LATENCY=3: four back-to-back reads of addrs 0..3 preloaded with 0x10..0x13 → acks in cycles k+3..k+6 carrying 0x10..0x13 in order.
- DEPTH=1000, AW=11: read addr 1000 and write addr 2047 → `o_wb_err` at latency, no ack, `o_wb_data`=0, and word 1000 mod DEPTH is unchanged.
- LATENCY=4: issue 3 reads, drop `i_wb_cyc` for one cycle at edge k+2 → no ack/err appears for those reads. A new read afterwards is acked normally.
- Assert reset for one cycle while 2 writes are in flight → no responses, INIT restarts, and the data written before reset is 0 after the sweep.
